// File: rtl/spike_rate_decoder.sv
// Rate-coded spike counter: counts neuron spikes over a window of enabled cycles
// and hands the count to a consumer via a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; no counting
// COUNT | window open; enabled cycles consume window length and accumulate spikes
module spike_rate_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               spike_in,
  input  logic               start,
  input  logic               continuous,
  input  logic [7:0]         window_len,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  input  logic               count_ready,
  output logic               overrun,
  output logic               busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [0:0]         state;
  logic [8:0]         remaining;
  logic [COUNT_W-1:0] spike_cnt;

  logic [8:0]         window_load;
  logic [COUNT_W-1:0] spike_sum;
  logic               window_done;
  logic               accept;

  always_comb begin
    window_load = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
    spike_sum   = spike_cnt;
    if (enable && spike_in && (spike_cnt != CNT_MAX))
      spike_sum = spike_cnt + CNT_ONE;
    window_done = (state == COUNT) && enable && (remaining == 9'd1);
    accept      = count_valid && count_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= 9'd0;
      spike_cnt   <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COUNT;
            remaining <= window_load;
            spike_cnt <= '0;
            overrun   <= 1'b0;
          end
        end
        default: begin
          if (window_done) begin
            // Back-to-back windows reload immediately so no spikes are lost.
            if (continuous) begin
              remaining <= window_load;
              spike_cnt <= '0;
            end else begin
              state     <= IDLE;
              remaining <= 9'd0;
              spike_cnt <= '0;
            end
          end else if (enable) begin
            remaining <= remaining - 9'd1;
            spike_cnt <= spike_sum;
          end
        end
      endcase

      // A pending unaccepted result wins over a new one; the loss is flagged.
      if (window_done) begin
        if (!count_valid || accept) begin
          count_out   <= spike_sum;
          count_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        count_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: window timing, saturation, gating,
// continuous mode, handshake overrun/accept collision and mid-window reset.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       spike_in;
  logic       start;
  logic       continuous;
  logic [7:0] window_len;
  logic [7:0] count_out;
  logic       count_valid;
  logic       count_ready;
  logic       overrun;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  spike_rate_decoder #(.COUNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .spike_in(spike_in),
    .start(start),
    .continuous(continuous),
    .window_len(window_len),
    .count_out(count_out),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    window_len = len;
    start = 1'b1;
    spike_in = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; spike_in = 1'b0; start = 1'b0;
    continuous = 1'b0; window_len = 8'd0; count_ready = 1'b1;
    tick(); tick();
    check("rst_valid", count_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count_out, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Window of 10, spikes on cycles 2..5, result visible after the 10th edge.
    do_start(8'd10);
    check("w10_busy", busy, 1);
    for (int i = 1; i <= 10; i++) begin
      spike_in = (i >= 2 && i <= 5);
      tick();
      if (i < 10) check($sformatf("w10_novalid_%0d", i), count_valid, 0);
    end
    spike_in = 1'b0;
    check("w10_valid", count_valid, 1);
    check("w10_count", count_out, 4);
    check("w10_busy_after", busy, 0);
    tick();
    check("w10_valid_drop", count_valid, 0);

    // window_len=0 means 256 cycles; constant spikes saturate at 255.
    do_start(8'd0);
    spike_in = 1'b1;
    for (int i = 1; i <= 255; i++) tick();
    check("w256_still_busy", busy, 1);
    check("w256_novalid", count_valid, 0);
    tick();
    check("w256_valid", count_valid, 1);
    check("w256_count", count_out, 255);
    tick();

    // Enable gating: window of 5 spread over 10 cycles, spikes ignored when disabled.
    do_start(8'd5);
    spike_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      enable = i[0];
      tick();
    end
    check("gate_novalid_9", count_valid, 0);
    check("gate_busy_9", busy, 1);
    enable = 1'b1;
    tick();
    check("gate_valid", count_valid, 1);
    check("gate_count", count_out, 5);
    tick();

    // Continuous, consumer stalled: second result dropped, overrun set.
    count_ready = 1'b0; continuous = 1'b1;
    do_start(8'd4);
    spike_in = 1'b1; tick(); tick();
    spike_in = 1'b0; tick(); tick();
    check("ov_valid1", count_valid, 1);
    check("ov_count1", count_out, 2);
    check("ov_busy_cont", busy, 1);
    continuous = 1'b0;
    spike_in = 1'b1; tick(); tick(); tick();
    spike_in = 1'b0; tick();
    check("ov_count_held", count_out, 2);
    check("ov_overrun", overrun, 1);
    check("ov_busy_end", busy, 0);
    count_ready = 1'b1;
    tick();
    check("ov_accepted", count_valid, 0);

    // Accept coincides with second window end: new value loads, valid never drops.
    count_ready = 1'b0; continuous = 1'b1;
    do_start(8'd3);
    spike_in = 1'b1; tick();
    spike_in = 1'b0; tick(); tick();
    check("col_valid1", count_valid, 1);
    check("col_count1", count_out, 1);
    check("col_overrun_clr", overrun, 0);
    continuous = 1'b0;
    spike_in = 1'b1; tick();
    check("col_hold_a", count_valid, 1);
    tick();
    check("col_hold_b", count_valid, 1);
    count_ready = 1'b1;
    tick();
    check("col_valid2", count_valid, 1);
    check("col_count2", count_out, 3);
    check("col_overrun", overrun, 0);
    spike_in = 1'b0;
    tick();
    check("col_drop", count_valid, 0);

    // Reset three cycles into an 8-cycle window discards the partial count.
    do_start(8'd8);
    spike_in = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", count_valid, 0);
    check("mid_rst_count", count_out, 0);
    reset = 1'b0; start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("mid_rst_nopulse_%0d", i), count_valid, 0);
    end
    do_start(8'd2);
    spike_in = 1'b1;
    tick(); tick();
    check("post_rst_valid", count_valid, 1);
    check("post_rst_count", count_out, 2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
